// File: rtl/qam16_demap_if.sv
// Sample/bit bus of the 16-QAM hard-decision demapper.
// master drives FFT samples and receives bits; slave is the demapper.
interface qam16_demap_if #(
  parameter int unsigned WIDTH = 16
);
  logic                    i_valid;
  logic signed [WIDTH-1:0] i_re;
  logic signed [WIDTH-1:0] i_im;
  logic                    o_valid;
  logic                    o_bit0;
  logic                    o_bit1;
  logic                    o_bit2;
  logic                    o_bit3;

  modport master (
    output i_valid, i_re, i_im,
    input  o_valid, o_bit0, o_bit1, o_bit2, o_bit3
  );

  modport slave (
    input  i_valid, i_re, i_im,
    output o_valid, o_bit0, o_bit1, o_bit2, o_bit3
  );
endinterface

// File: rtl/qam16_demap.sv
// Hard-decision 16-QAM (802.11a Gray) demapper, one complex sample per cycle, 1-cycle latency.
// Define QAM16_DEMAP_INREG_EN to add an input register stage (latency 2).
module qam16_demap #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned THRESH = 2048
) (
  input logic             clk,
  input logic             rst_n,
  qam16_demap_if.slave    bus
);
  localparam logic [WIDTH-1:0] Thresh = WIDTH'(THRESH);
  localparam logic [WIDTH-1:0] MaxMag = {1'b0, {(WIDTH-1){1'b1}}};

  logic                    s_valid;
  logic signed [WIDTH-1:0] s_re;
  logic signed [WIDTH-1:0] s_im;

`ifdef QAM16_DEMAP_INREG_EN
  logic                    in_valid_q;
  logic signed [WIDTH-1:0] in_re_q;
  logic signed [WIDTH-1:0] in_im_q;

  // Data only captured on valid so X on idle inputs never reaches the slicer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_valid_q <= 1'b0;
      in_re_q    <= '0;
      in_im_q    <= '0;
    end else begin
      in_valid_q <= bus.i_valid;
      if (bus.i_valid) begin
        in_re_q <= bus.i_re;
        in_im_q <= bus.i_im;
      end
    end
  end

  assign s_valid = in_valid_q;
  assign s_re    = in_re_q;
  assign s_im    = in_im_q;
`else
  assign s_valid = bus.i_valid;
  assign s_re    = bus.i_re;
  assign s_im    = bus.i_im;
`endif

  // Returns {sign, inner}; most-negative input saturates to an outer decision.
  function automatic logic [1:0] slice(input logic signed [WIDTH-1:0] x);
    logic [WIDTH-1:0] mag;
    if (!x[WIDTH-1]) begin
      mag = x;
    end else if (x[WIDTH-2:0] == '0) begin
      mag = MaxMag;
    end else begin
      mag = -x;
    end
    return {~x[WIDTH-1], (mag < Thresh)};
  endfunction

  logic [3:0] bits_d;
  logic [3:0] bits_q;
  logic       valid_q;

  always_comb begin
    bits_d       = '0;
    bits_d[3:2]  = slice(s_re);
    bits_d[1:0]  = slice(s_im);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      bits_q  <= '0;
    end else begin
      valid_q <= s_valid;
      if (s_valid) begin
        bits_q <= bits_d;
      end
    end
  end

  assign bus.o_valid = valid_q;
  assign bus.o_bit0  = bits_q[3];
  assign bus.o_bit1  = bits_q[2];
  assign bus.o_bit2  = bits_q[1];
  assign bus.o_bit3  = bits_q[0];
endmodule

// File: tb/tb_qam16_demap.sv
// Self-checking bench for qam16_demap: scoreboard queue of expected outputs, one entry per cycle.
module tb_qam16_demap;
  localparam int unsigned WIDTH  = 16;
  localparam int unsigned THRESH = 2048;
`ifdef QAM16_DEMAP_INREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct packed {
    logic       v;
    logic [3:0] bits;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  qam16_demap_if #(.WIDTH(WIDTH)) bus ();

  qam16_demap #(.WIDTH(WIDTH), .THRESH(THRESH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t       sb[$];
  logic [3:0] held;
  int         checks   = 0;
  int         failures = 0;

  // Bits returned in serial order {b0,b1,b2,b3}.
  function automatic logic [3:0] ref_bits(input int re, input int im);
    int ar;
    int ai;
    ar = (re < 0) ? -re : re;
    ai = (im < 0) ? -im : im;
    return {(re >= 0), (ar < int'(THRESH)), (im >= 0), (ai < int'(THRESH))};
  endfunction

  task automatic step(input logic rst, input logic v, input int re, input int im,
                      input logic [3:0] eb, input string tag);
    exp_t e;
    logic [3:0] got;
    rst_n       = rst;
    bus.i_valid = v;
    if (v) begin
      bus.i_re = re[WIDTH-1:0];
      bus.i_im = im[WIDTH-1:0];
    end else begin
      bus.i_re = 'x;
      bus.i_im = 'x;
    end
    if (!rst) begin
      sb.delete();
      repeat (LAT - 1) sb.push_back('0);
    end
    e.v    = v && rst;
    e.bits = eb;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (e.v) held = e.bits;
    if (!rst) held = 4'b0000;
    got = {bus.o_bit0, bus.o_bit1, bus.o_bit2, bus.o_bit3};
    checks++;
    assert (bus.o_valid === e.v) else begin
      failures++;
      $error("FAIL %s o_valid: got %b want %b", tag, bus.o_valid, e.v);
    end
    checks++;
    assert (got === held) else begin
      failures++;
      $error("FAIL %s bits: got %b want %b", tag, got, held);
    end
  endtask

  int levels[4] = '{-3072, -1024, 1024, 3072};

  initial begin
    int re;
    int im;
    logic v;
    held        = 4'b0000;
    rst_n       = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_re    = '0;
    bus.i_im    = '0;

    // Reset held with a valid sample present: sample dropped, outputs zero.
    step(1'b0, 1'b1, 3072, 3072, 4'b1010, "reset0");
    step(1'b0, 1'b1, 3072, 3072, 4'b1010, "reset1");
    repeat (LAT) step(1'b1, 1'b0, 0, 0, 4'b0000, "post_reset");

    // Constellation sweep back-to-back, then o_valid must drop.
    foreach (levels[a]) begin
      foreach (levels[b]) begin
        step(1'b1, 1'b1, levels[a], levels[b], ref_bits(levels[a], levels[b]), "sweep");
      end
    end
    repeat (LAT) step(1'b1, 1'b0, 0, 0, 4'b0000, "sweep_end");

    // Directed points with literal expectations.
    step(1'b1, 1'b1, 3072, -1024, 4'b1001, "ex_3072_m1024");
    step(1'b1, 1'b1, -1024, 1024, 4'b0111, "ex_m1024_1024");
    step(1'b1, 1'b1, 0, 0, 4'b1111, "zero");
    step(1'b1, 1'b1, 2048, -2048, 4'b1000, "thresh_eq");
    step(1'b1, 1'b1, 2047, -2047, 4'b1101, "thresh_m1");
    step(1'b1, 1'b1, -32768, 32767, 4'b0010, "extremes");
    step(1'b1, 1'b1, -2048, 2048, 4'b0010, "thresh_neg");
    step(1'b1, 1'b1, -2047, -1, 4'b0101, "inner_neg");
    repeat (LAT) step(1'b1, 1'b0, 0, 0, 4'b0000, "directed_end");

    // Gapped stream 1,0,1,1,0.
    step(1'b1, 1'b1, 1024, 3072, 4'b1110, "gap0");
    step(1'b1, 1'b0, 0, 0, 4'b0000, "gap1");
    step(1'b1, 1'b1, -3072, -3072, 4'b0000, "gap2");
    step(1'b1, 1'b1, 3072, 1024, 4'b1011, "gap3");
    step(1'b1, 1'b0, 0, 0, 4'b0000, "gap4");
    repeat (LAT) step(1'b1, 1'b0, 0, 0, 4'b0000, "gap_end");

    // Reset mid-stream: in-flight samples dropped, first valid after release is fresh.
    step(1'b1, 1'b1, 3072, 3072, 4'b1010, "mid0");
    step(1'b1, 1'b1, -1024, -1024, 4'b0101, "mid1");
    step(1'b0, 1'b1, 1024, 1024, 4'b1111, "mid_rst");
    step(1'b1, 1'b1, -3072, 1024, 4'b0011, "mid_after");
    repeat (LAT) step(1'b1, 1'b0, 0, 0, 4'b0000, "mid_end");

    // Random stream vs. reference model.
    for (int n = 0; n < 64; n++) begin
      re = int'($urandom_range(0, 65535)) - 32768;
      im = int'($urandom_range(0, 65535)) - 32768;
      if (n % 4 == 0) begin
        re = int'($urandom_range(0, 8191)) - 4096;
        im = int'($urandom_range(0, 8191)) - 4096;
      end
      v = ($urandom_range(0, 7) != 0);
      step(1'b1, v, re, im, ref_bits(re, im), "random");
    end
    repeat (LAT) step(1'b1, 1'b0, 0, 0, 4'b0000, "random_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/qam16_demap.md
Name: qam16_demap

Overview:
- Hard-decision 16-QAM demapper at the back end of the OFDM receive chain, directly after the FFT (one complex subcarrier sample per cycle).
- Slices each signed I/Q sample against a programmable decision threshold.
- Emits 4 Gray-coded bits per symbol with a valid strobe for the downstream bit-deinterleave/decoder stage.

Parameters:
- WIDTH, 16, bit width of signed two's-complement i_re / i_im.
- THRESH, 2048, positive inner/outer amplitude decision boundary, same scale as the inputs (nominal levels ±1024 / ±3072). Legal range 1 … 2^(WIDTH-1)-1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- i_valid  input  1  input sample qualifier.
- i_re  input  WIDTH  signed real part (I) of FFT output.
- i_im  input  WIDTH  signed imaginary part (Q) of FFT output.
- o_valid  output  1  output bits qualifier.
- o_bit0  output  1  I sign bit (first bit of symbol in serial order).
- o_bit1  output  1  I amplitude bit.
- o_bit2  output  1  Q sign bit.
- o_bit3  output  1  Q amplitude bit (last bit of symbol).

Behaviour:
- Mapping (802.11a Gray), per axis, pairs (b0,b1) from I and (b2,b3) from Q:
  - level -3 → 00, -1 → 01, +1 → 11, +3 → 10.
  - o_bit0 = 1 when i_re >= 0, else 0; zero counts as non-negative.
  - o_bit1 = 1 when |i_re| < THRESH (inner level), else 0; |i_re| == THRESH is outer (0).
  - o_bit2 / o_bit3: identical rules applied to i_im.
- Absolute value:
  - Computed at WIDTH bits with saturation: most-negative input (-32768 at WIDTH=16) maps to 2^(WIDTH-1)-1, giving an outer decision.
  - No overflow wrap permitted.
- Latency: exactly 1 clock. Inputs sampled at rising edge N with i_valid=1 → o_valid=1 and the bits valid after edge N, held through edge N+1.
- Throughput: one symbol per cycle, back-to-back, no stalls.
- No backpressure; no ready signal.
- i_valid=0 at an edge → o_valid=0 after that edge.
- Bit outputs when o_valid=0:
  - Hold their previous value.
  - Don't-care for checking, but must never be X after reset.
- i_re / i_im ignored when i_valid=0 (X on inputs must not propagate into held bits).
- Reset (rst_n=0 at a rising edge):
  - o_valid=0 and o_bit0..o_bit3=0 after that edge.
  - Reset has priority over i_valid.
  - A sample presented in the same cycle as reset is dropped.
- Reset mid-stream:
  - Output stream stops cleanly.
  - The first valid after deassertion produces output 1 cycle later with no stale data.
- No internal state beyond the output register stage; no FSM.

Optional Feature:
- Macro QAM16_DEMAP_INREG_EN.
- Defined:
  - Adds an input register stage for i_valid / i_re / i_im, for timing closure after the FFT.
  - Latency becomes exactly 2 clocks; throughput still 1/cycle.
  - Reset clears both stages (valid=0, data=0).
- Undefined: latency 1 as specified above. Mapping identical in both builds.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with i_valid=1 → o_valid=0, all bits 0 throughout and 1 cycle after release.
- Constellation sweep: feed all 16 points (re,im ∈ {-3072,-1024,1024,3072}) back-to-back.
  - Example: (3072,-1024) → 1001; (-1024,1024) → 0111.
  - o_valid high for exactly 16 consecutive cycles starting 1 cycle after first valid.
- Boundaries:
  - (0,0) → 1111.
  - (2048,-2048) → 1000.
  - (2047,-2047) → 1101.
  - (-32768,32767) → 0010.
- Gapped stream: valid pattern 1,0,1,1,0 → o_valid 1,0,1,1,0 delayed one cycle; bits match the respective samples.
- Random 64-sample stream vs. reference model → 256 bits compared, 0 errors.
  - Repeat with QAM16_DEMAP_INREG_EN defined: 2-cycle latency, same bits.
